// File: rtl/freq_key_if.sv
// Key inputs and frequency outputs of the key-to-FREQ_CTRL controller.
// The controller uses the slave modport; the driver of the buttons uses master.
interface freq_key_if;
    logic        key_step;
    logic        key_up;
    logic        key_down;
    logic [31:0] FREQ_CTRL;
    logic [2:0]  step_idx;
    logic        freq_upd;

    modport slave (
        input  key_step, key_up, key_down,
        output FREQ_CTRL, step_idx, freq_upd
    );

    modport master (
        output key_step, key_up, key_down,
        input  FREQ_CTRL, step_idx, freq_upd
    );
endinterface

// File: rtl/freq_key_ctrl.sv
// Three active-low buttons -> saturating decimal FREQ_CTRL value with selectable step digit.
// Optional macro FREQ_KEY_AUTO_REPEAT_EN adds hold-to-repeat on the up and down keys.
module freq_key_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter logic [31:0] FREQ_MIN        = 32'd0,
    parameter logic [31:0] FREQ_MAX        = 32'd999999,
    parameter logic [31:0] FREQ_INIT       = 32'd1000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    freq_key_if.slave  bus
);

    localparam int unsigned     DB_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

    generate
        if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0 ||
            FREQ_MIN > FREQ_MAX || FREQ_INIT < FREQ_MIN || FREQ_INIT > FREQ_MAX) begin : g_bad_param
            $error("freq_key_ctrl: inconsistent parameters");
        end
    endgenerate

    // Key order in all per-key vectors: 0 = step, 1 = up, 2 = down.
    logic [2:0] key_raw;
    logic [2:0] key_level;
    logic [2:0] key_press;

    assign key_raw = {bus.key_down, bus.key_up, bus.key_step};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_key
            logic [1:0]      sync_reg;
            logic            deb_reg;
            logic            prev_reg;
            logic [DB_W-1:0] cnt_reg;

            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    sync_reg <= 2'b11;
                    deb_reg  <= 1'b1;
                    prev_reg <= 1'b1;
                    cnt_reg  <= '0;
                end else begin
                    sync_reg <= {sync_reg[0], key_raw[gi]};
                    prev_reg <= deb_reg;
                    if (sync_reg[1] == deb_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_LAST) begin
                        deb_reg <= sync_reg[1];
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + DB_ONE;
                    end
                end
            end

            assign key_level[gi] = deb_reg;
            assign key_press[gi] = prev_reg & ~deb_reg;
        end
    endgenerate

    // rep_tick[0] repeats the up key, rep_tick[1] the down key.
    logic [1:0] rep_tick;

`ifdef FREQ_KEY_AUTO_REPEAT_EN
    localparam logic [1:0]  ST_IDLE     = 2'd0;
    localparam logic [1:0]  ST_HOLD     = 2'd1;
    localparam logic [1:0]  ST_REPEAT   = 2'd2;
    localparam logic [31:0] DELAY_LAST  = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] PERIOD_LAST = 32'(REPEAT_PERIOD - 1);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rep
            logic [1:0]  state_reg;
            logic [31:0] cnt_reg;

            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= 32'd0;
                end else begin
                    case (state_reg)
                        ST_IDLE: begin
                            if (key_press[gi+1]) begin
                                state_reg <= ST_HOLD;
                                cnt_reg   <= 32'd0;
                            end
                        end
                        ST_HOLD: begin
                            if (key_level[gi+1]) begin
                                state_reg <= ST_IDLE;
                            end else if (cnt_reg == DELAY_LAST) begin
                                state_reg <= ST_REPEAT;
                                cnt_reg   <= 32'd0;
                            end else begin
                                cnt_reg <= cnt_reg + 32'd1;
                            end
                        end
                        ST_REPEAT: begin
                            if (key_level[gi+1]) begin
                                state_reg <= ST_IDLE;
                            end else if (cnt_reg == PERIOD_LAST) begin
                                cnt_reg <= 32'd0;
                            end else begin
                                cnt_reg <= cnt_reg + 32'd1;
                            end
                        end
                        default: state_reg <= ST_IDLE;
                    endcase
                end
            end

            assign rep_tick[gi] = ~key_level[gi+1] &
                                  (((state_reg == ST_HOLD)   && (cnt_reg == DELAY_LAST)) ||
                                   ((state_reg == ST_REPEAT) && (cnt_reg == PERIOD_LAST)));
        end
    endgenerate
`else
    assign rep_tick = 2'b00;
`endif

    function automatic logic [31:0] step_of(input logic [2:0] idx);
        case (idx)
            3'd0:    step_of = 32'd1;
            3'd1:    step_of = 32'd10;
            3'd2:    step_of = 32'd100;
            3'd3:    step_of = 32'd1000;
            3'd4:    step_of = 32'd10000;
            3'd5:    step_of = 32'd100000;
            default: step_of = 32'd1;
        endcase
    endfunction

    logic [31:0] freq_reg, freq_next;
    logic [2:0]  step_idx_reg, step_idx_next;
    logic        freq_upd_reg;
    logic        up_act, dn_act;
    logic [31:0] step_val;
    logic [32:0] up_sum, dn_floor;

    assign up_act = key_press[1] | rep_tick[0];
    assign dn_act = key_press[2] | rep_tick[1];

    // 33-bit compares keep saturation exact at both ends without wrap.
    always_comb begin
        step_val      = step_of(step_idx_reg);
        up_sum        = {1'b0, freq_reg} + {1'b0, step_val};
        dn_floor      = {1'b0, FREQ_MIN} + {1'b0, step_val};
        freq_next     = freq_reg;
        step_idx_next = step_idx_reg;
        if (up_act && !dn_act) begin
            freq_next = (up_sum > {1'b0, FREQ_MAX}) ? FREQ_MAX : up_sum[31:0];
        end else if (dn_act && !up_act) begin
            freq_next = ({1'b0, freq_reg} < dn_floor) ? FREQ_MIN : (freq_reg - step_val);
        end
        if (key_press[0]) begin
            step_idx_next = (step_idx_reg == 3'd5) ? 3'd0 : (step_idx_reg + 3'd1);
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            freq_reg     <= FREQ_INIT;
            step_idx_reg <= 3'd0;
            freq_upd_reg <= 1'b0;
        end else begin
            freq_reg     <= freq_next;
            step_idx_reg <= step_idx_next;
            freq_upd_reg <= (freq_next != freq_reg);
        end
    end

    assign bus.FREQ_CTRL = freq_reg;
    assign bus.step_idx  = step_idx_reg;
    assign bus.freq_upd  = freq_upd_reg;

endmodule
